// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: frame-sync state encoding
// and counter widths.
package snake_pkg;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_TICK  = 2'd1;
  localparam logic [1:0] FS_WAIT  = 2'd2;
  localparam logic [1:0] FS_LATCH = 2'd3;

  localparam int DIV_W   = 4;
  localparam int STALL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = FS_IDLE,
    ST_TICK  = FS_TICK,
    ST_WAIT  = FS_WAIT,
    ST_LATCH = FS_LATCH
  } fs_state_e;

endpackage

// File: rtl/frame_sync_ctrl_tick_divider.sv
// Frames-per-tick divider: decides on each evaluated frame whether a game
// tick is due. tick_div of 0 behaves as 1; pause freezes the count.
module tick_divider
  import snake_pkg::*;
(
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             eval,
  input  logic             pause,
  input  logic [DIV_W-1:0] tick_div,
  output logic             tick_due
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] last_idx;

  always_comb begin
    last_idx  = (tick_div == '0) ? '0 : tick_div - DIV_W'(1);
    // >= rather than == so lowering tick_div mid-count cannot strand the counter
    tick_due  = !pause && (div_cnt_q >= last_idx);
    div_cnt_d = div_cnt_q;
    if (eval && !pause) begin
      div_cnt_d = tick_due ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Per-frame snapshot sequencer: optional game tick, wait for completion, then
// frame_start strobe. stall_cnt is built only with FRAME_SYNC_STATS_EN.
// Handshake: tick_req and game_done are single-cycle pulses; game_done is
// accepted only in WAIT, and frame_start is never raised while update_busy.
module frame_sync_ctrl
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int FCNT_W      = 16
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               frame_end,
  input  logic [DIV_W-1:0]   tick_div,
  input  logic               pause,
  input  logic               game_done,
  output logic               tick_req,
  output logic               frame_start,
  output logic               update_busy,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [1:0]         state_dbg
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  fs_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              tick_due;
  logic              div_eval;
  logic              timeout;
  logic              missed;

  assign div_eval = frame_end && (state_q == ST_IDLE);

  tick_divider u_tick_divider (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .eval     (div_eval),
    .pause    (pause),
    .tick_div (tick_div),
    .tick_due (tick_due)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    timeout     = 1'b0;
    missed      = frame_end && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (frame_end) begin
          state_d = tick_due ? ST_TICK : ST_LATCH;
        end
      end
      ST_TICK: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        // game_done takes priority over a coincident timeout
        if (game_done) begin
          state_d = ST_LATCH;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_LATCH: begin
        state_d     = ST_IDLE;
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // A missed frame coinciding with a timeout is one stall event
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((missed || timeout) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = missed | timeout;
  assign stall_cnt    = '0;
`endif

  assign tick_req    = (state_q == ST_TICK);
  assign update_busy = (state_q == ST_TICK) || (state_q == ST_WAIT);
  assign frame_start = (state_q == ST_LATCH);
  assign frame_cnt   = frame_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl with TIMEOUT_CYC = 16; stall_cnt
// expectations follow FRAME_SYNC_STATS_EN.
module tb_frame_sync_ctrl;
  import snake_pkg::*;

`ifdef FRAME_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        frame_end;
  logic [3:0]  tick_div;
  logic        pause;
  logic        game_done;
  logic        tick_req;
  logic        frame_start;
  logic        update_busy;
  logic [15:0] frame_cnt;
  logic [7:0]  stall_cnt;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_fs = 0;
  int n_overlap = 0;
  int base_tick;
  int base_fs;

  frame_sync_ctrl #(.TIMEOUT_CYC(16), .FCNT_W(16)) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .frame_end   (frame_end),
    .tick_div    (tick_div),
    .pause       (pause),
    .game_done   (game_done),
    .tick_req    (tick_req),
    .frame_start (frame_start),
    .update_busy (update_busy),
    .frame_cnt   (frame_cnt),
    .stall_cnt   (stall_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (tick_req === 1'b1) n_tick++;
    if (frame_start === 1'b1) n_fs++;
    if ((frame_start === 1'b1) && (update_busy === 1'b1)) n_overlap++;
  end

  function automatic int exp_stall(input int n);
    return STATS ? n : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(negedge clk_pix);
    frame_end = 1'b0;
  endtask

  task automatic pulse_gd();
    game_done = 1'b1;
    @(negedge clk_pix);
    game_done = 1'b0;
  endtask

  task automatic latch_frame(input string tag);
    pulse_fe();
    check({tag, "_fs"}, 32'(frame_start), 32'd1);
    check({tag, "_notick"}, 32'(tick_req), 32'd0);
    check({tag, "_idle_busy"}, 32'(update_busy), 32'd0);
    cyc(1);
    check({tag, "_fs_end"}, 32'(frame_start), 32'd0);
  endtask

  task automatic tick_frame(input string tag);
    pulse_fe();
    check({tag, "_tick"}, 32'(tick_req), 32'd1);
    check({tag, "_busy"}, 32'(update_busy), 32'd1);
    check({tag, "_nofs"}, 32'(frame_start), 32'd0);
    cyc(5);
    pulse_gd();
    check({tag, "_fs"}, 32'(frame_start), 32'd1);
    check({tag, "_nobusy"}, 32'(update_busy), 32'd0);
    cyc(1);
    check({tag, "_fs_end"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; frame_end = 1'b0; pause = 1'b0; game_done = 1'b0; tick_div = 4'd3;
    cyc(3);
    check("rst_tick_req", 32'(tick_req), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(update_busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(FS_IDLE));
    rst_n = 1'b1;
    cyc(1);

    // tick every third frame
    base_tick = n_tick; base_fs = n_fs;
    for (int f = 1; f <= 9; f++) begin
      if (f % 3 == 0) tick_frame($sformatf("div3_f%0d", f));
      else latch_frame($sformatf("div3_f%0d", f));
      cyc(1);
    end
    cyc(1);
    check("div3_ticks", 32'(n_tick - base_tick), 32'd3);
    check("div3_starts", 32'(n_fs - base_fs), 32'd9);
    check("div3_frame_cnt", 32'(frame_cnt), 32'd9);

    // tick_div 0 acts as 1
    tick_div = 4'd0;
    base_tick = n_tick;
    for (int f = 1; f <= 3; f++) begin
      tick_frame($sformatf("div0_f%0d", f));
      cyc(1);
    end
    cyc(1);
    check("div0_ticks", 32'(n_tick - base_tick), 32'd3);
    check("div0_overlap", 32'(n_overlap), 32'd0);
    check("div0_frame_cnt", 32'(frame_cnt), 32'd12);

    // timeout: no game_done, IDLE 18 cycles after frame_end
    tick_div = 4'd1;
    base_fs = n_fs;
    pulse_fe();
    check("to_tick", 32'(tick_req), 32'd1);
    cyc(16);
    check("to_still_wait", 32'(state_dbg), 32'(FS_WAIT));
    check("to_still_busy", 32'(update_busy), 32'd1);
    cyc(1);
    check("to_idle", 32'(state_dbg), 32'(FS_IDLE));
    check("to_nobusy", 32'(update_busy), 32'd0);
    cyc(2);
    check("to_no_start", 32'(n_fs - base_fs), 32'd0);
    check("to_stall", 32'(stall_cnt), 32'(exp_stall(1)));
    check("to_frame_cnt", 32'(frame_cnt), 32'd12);

    // frame_end while waiting is missed
    base_fs = n_fs;
    pulse_fe();
    cyc(2);
    pulse_fe();
    check("miss_wait_state", 32'(state_dbg), 32'(FS_WAIT));
    check("miss_wait_nofs", 32'(frame_start), 32'd0);
    cyc(1);
    pulse_gd();
    check("miss_fs", 32'(frame_start), 32'd1);
    cyc(2);
    check("miss_starts", 32'(n_fs - base_fs), 32'd1);
    check("miss_stall", 32'(stall_cnt), 32'(exp_stall(2)));
    check("miss_frame_cnt", 32'(frame_cnt), 32'd13);

    // pause holds the divider
    pause = 1'b1; tick_div = 4'd2;
    base_tick = n_tick; base_fs = n_fs;
    for (int f = 1; f <= 4; f++) begin
      latch_frame($sformatf("pause_f%0d", f));
      cyc(1);
    end
    cyc(1);
    check("pause_ticks", 32'(n_tick - base_tick), 32'd0);
    check("pause_starts", 32'(n_fs - base_fs), 32'd4);
    pause = 1'b0;
    latch_frame("resume_f1");
    cyc(1);
    tick_frame("resume_f2");
    cyc(2);
    check("resume_frame_cnt", 32'(frame_cnt), 32'd19);

    // back-to-back frame_end: second lands in LATCH
    pause = 1'b1;
    frame_end = 1'b1;
    cyc(1);
    check("b2b_first_fs", 32'(frame_start), 32'd1);
    cyc(1);
    frame_end = 1'b0;
    check("b2b_second_nofs", 32'(frame_start), 32'd0);
    check("b2b_idle", 32'(state_dbg), 32'(FS_IDLE));
    cyc(2);
    check("b2b_stall", 32'(stall_cnt), 32'(exp_stall(3)));
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd20);
    pause = 1'b0;

    // reset in WAIT abandons the update
    tick_div = 4'd1;
    base_fs = n_fs;
    pulse_fe();
    cyc(2);
    check("rw_in_wait", 32'(state_dbg), 32'(FS_WAIT));
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("rw_tick_req", 32'(tick_req), 32'd0);
    check("rw_frame_start", 32'(frame_start), 32'd0);
    check("rw_busy", 32'(update_busy), 32'd0);
    check("rw_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rw_stall", 32'(stall_cnt), 32'd0);
    check("rw_state", 32'(state_dbg), 32'(FS_IDLE));
    pulse_gd();
    check("rw_late_done_state", 32'(state_dbg), 32'(FS_IDLE));
    check("rw_late_done_nofs", 32'(frame_start), 32'd0);
    cyc(2);
    check("rw_no_start", 32'(n_fs - base_fs), 32'd0);

    // reset clears a part-way divider count
    tick_div = 4'd3;
    latch_frame("rd_pre");
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    tick_div = 4'd2;
    latch_frame("rd_f1");
    cyc(1);
    tick_frame("rd_f2");
    cyc(2);
    check("rd_frame_cnt", 32'(frame_cnt), 32'd2);
    check("rd_stall", 32'(stall_cnt), 32'd0);
    check("final_overlap", 32'(n_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

- Sequences the per-frame snapshot of game state into the render domain.
- On each end-of-frame event it decides whether a game tick is due, requests one update from the game logic and waits for completion. Only then does it issue the one-cycle `frame_start` strobe that makes the frame latch capture head, apple, length and body buses.
- Sits between the VGA timing generator, the snake game logic and the frame latch, all on `clk_pix`.

## Interface

Parameters:
- `TIMEOUT_CYC`, 4096: max cycles to wait for `game_done` after `tick_req`.
- `FCNT_W`, 16: width of `frame_cnt`.

Ports:
- `clk_pix`, in, 1: pixel clock; the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `frame_end`, in, 1: one-cycle pulse from timing generator at end of visible area.
- `tick_div`, in, 4: frames per game tick; 0 treated as 1.
- `pause`, in, 1: suppresses ticks; latching continues.
- `game_done`, in, 1: one-cycle pulse from game logic, update complete.
- `tick_req`, out, 1: one-cycle request to game logic to advance one step.
- `frame_start`, out, 1: one-cycle capture strobe to the frame latch.
- `update_busy`, out, 1: high while an update is outstanding.
- `frame_cnt`, out, FCNT_W: count of `frame_start` pulses, wraps.
- `stall_cnt`, out, 8: timeouts plus missed frames, saturating at 255.

## Operation

States: IDLE, TICK, WAIT_DONE, LATCH.

Transitions:
- IDLE + `frame_end` + tick due → TICK.
- IDLE + `frame_end` + no tick due → LATCH.
- TICK → WAIT_DONE unconditionally; `tick_req` is high only in TICK.
- WAIT_DONE + `game_done` → LATCH.
- WAIT_DONE + timer reaches `TIMEOUT_CYC` → IDLE with no latch. The old snapshot is held and `stall_cnt` increments.
- LATCH → IDLE; `frame_start` is high only in LATCH, and `frame_cnt` increments.

Divider:
- `div_cnt` (4 bits) is evaluated only on `frame_end` seen in IDLE.
- Let `N = max(tick_div,1)`.
- If `pause` is set: no tick is due and `div_cnt` holds.
- Else if `div_cnt >= N-1`: a tick is due and `div_cnt` is cleared to 0. The `>=` covers `tick_div` lowered mid-count.
- Else `div_cnt` increments.

Other behaviour:
- `update_busy` is high in TICK and WAIT_DONE.
- `game_done` outside WAIT_DONE is ignored. This includes `game_done` in the TICK cycle itself.
- `frame_end` outside IDLE is a missed frame: no latch, `stall_cnt` increments.
  - If `frame_end` coincides with a timeout, `stall_cnt` increments by 1 only.
  - If `frame_end` arrives in the LATCH cycle it is also missed.
- The wait timer clears on TICK entry and counts each WAIT_DONE cycle.
- If `game_done` and the timeout occur in the same cycle, `game_done` wins and the FSM goes to LATCH.
- Invariant: `frame_start` is never asserted while `update_busy` is high, so the latch never captures a half-updated state.

## Timing

- All outputs are registered, decoded from the state register.
- Reset (`rst_n` low at a rising edge) forces:
  - state IDLE;
  - `tick_req`, `frame_start`, `update_busy` = 0;
  - `frame_cnt`, `stall_cnt`, `div_cnt`, wait timer = 0.
- Reset mid-update abandons the outstanding `tick_req`; a late `game_done` is then ignored (FSM is in IDLE).
- No-tick frame: `frame_end` at cycle k gives `frame_start` at k+1.
- Tick frame, with `game_done` at cycle d ≥ k+2:
  - `frame_end` at cycle k;
  - `tick_req` at k+1;
  - WAIT_DONE from k+2;
  - `frame_start` at d+1.
- Timeout: with `game_done` absent, return to IDLE at cycle k+2+`TIMEOUT_CYC`.
- Back-to-back `frame_end` one cycle apart: the second pulse is missed in LATCH or TICK and counted in `stall_cnt`.

## Configuration

- Macro `FRAME_SYNC_STATS_EN`.
- Defined: `stall_cnt` logic is built as specified.
- Undefined: the counter is removed and `stall_cnt` is tied to 0. FSM, divider and `frame_cnt` behaviour are identical either way.

## Structure

- Shared package `snake_pkg` holds:
  - state encoding localparams `FS_IDLE`, `FS_TICK`, `FS_WAIT`, `FS_LATCH` (2-bit);
  - `DIV_W` = 4;
  - `STALL_W` = 8.
- One sub-module, `tick_divider`.
  - Inputs: `clk_pix`, `rst_n`, evaluate strobe, `pause`, `tick_div`.
  - Output: `tick_due`.
  - Holds `div_cnt` and the N-1 compare.
- FSM, wait timer and counters stay in `frame_sync_ctrl`.

## Test plan

- `tick_div`=3, `game_done` 5 cycles after each `tick_req`, 9 `frame_end` pulses:
  - 3 `tick_req`, on frames 3, 6 and 9;
  - 9 `frame_start`, each at `game_done`+1 or `frame_end`+1;
  - `frame_cnt`=9.
- `tick_div`=0, `game_done` 5 cycles after each `tick_req`:
  - every `frame_end` produces `tick_req`;
  - `frame_start` never overlaps `update_busy`.
- `tick_div`=1, `game_done` withheld, `TIMEOUT_CYC`=16:
  - return to IDLE 18 cycles after `frame_end`;
  - no `frame_start`;
  - `stall_cnt`=1.
- `frame_end` during WAIT_DONE, then `game_done`:
  - `stall_cnt` +1;
  - exactly one `frame_start`.
- `pause`=1 across 4 frames with `tick_div`=2:
  - no `tick_req`, 4 `frame_start`, divider holds.
  - Release `pause`: first `tick_req` on 2nd frame.
- Assert `rst_n`=0 in WAIT_DONE, release, then pulse `game_done`:
  - all outputs 0;
  - no `frame_start`;
  - next `frame_end` follows a fresh divider count.
